// File: rtl/switch_output_port.sv
// Per-output-port packet forwarder: pops one whole packet from the
// granted input FIFO head into a registered valid/ready output stage.
module switch_output_port #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [SEL_W-1:0]                 select,
  input  logic                             grant_valid,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [NUM_INPUTS-1:0]            pkt_done,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  input  logic                             out_ready,
  output logic                             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam logic [LEN_WIDTH:0] REM_ONE =
    (LEN_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [SEL_W-1:0]      cur_sel;
  logic [LEN_WIDTH:0]    remaining;
  logic                  gap_cnt;

  logic [NUM_INPUTS-1:0] sel_oh;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic                  active;
  logic                  slot_free;
  logic                  take;
  logic                  is_tail;

  // Mux the latched input's FIFO head and build its one-hot mask.
  always_comb begin
    sel_oh     = '0;
    head_valid = 1'b0;
    head_data  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        sel_oh[i]  = 1'b1;
        head_valid = in_valid[i];
        head_data  =
          in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hdr_len   = head_data[LEN_WIDTH-1:0];
  assign active    = (state == HDR) ||
                     (state == PAYLOAD);
  assign slot_free = !out_valid || out_ready;
  assign take      = active && head_valid &&
                     slot_free;
  assign is_tail   =
    ((state == HDR) && (hdr_len == '0)) ||
    ((state == PAYLOAD) && (remaining == REM_ONE));

  assign in_ready = (active && slot_free) ?
                    sel_oh : '0;
  assign pkt_done = (take && is_tail) ?
                    sel_oh : '0;
  assign busy     = (state != IDLE);

  // Packet sequencing: grant latch, header, payload count, gap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cur_sel   <= '0;
      remaining <= '0;
      gap_cnt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_sel <= select;
            state   <= HDR;
          end
        end
        HDR: begin
          if (take) begin
            remaining <= {1'b0, hdr_len};
            if (hdr_len == '0) begin
              gap_cnt <= 1'b0;
              state   <= GAP;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (take) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              gap_cnt <= 1'b0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt) begin
            gap_cnt <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: a new word wins over draining the old one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_output_port.sv
// Randomized scoreboard bench for switch_output_port.
// Input FIFOs, arbiter and sink are modelled at packet level.
module tb_switch_output_port;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int SW = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [SW-1:0] select;
  logic          grant_valid;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  pkt_done;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;

  always #5 CLK = ~CLK;

  switch_output_port #(
    .NUM_INPUTS(N),
    .DATA_WIDTH(DW),
    .LEN_WIDTH(LW)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .select(select),
    .grant_valid(grant_valid),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .pkt_done(pkt_done),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] words [N][$];
  bit            tails [N][$];
  int            lens  [N][$];
  logic [DW-1:0] expq  [$];

  int granted    = 0;
  bit grant_prev = 1'b0;
  int pop_cnt    = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic add_pkt(input int inp, input int len);
    logic [DW-1:0] w;
    w = $urandom;
    w[LW-1:0] = LW'(len);
    words[inp].push_back(w);
    tails[inp].push_back(len == 0);
    for (int k = 0; k < len; k++) begin
      words[inp].push_back($urandom);
      tails[inp].push_back(k == len - 1);
    end
    lens[inp].push_back(len);
  endtask

  function automatic bit drained();
    bit d;
    d = (expq.size() == 0) && !busy;
    for (int i = 0; i < N; i++)
      if (words[i].size() != 0 ||
          lens[i].size() != 0)
        d = 1'b0;
    return d;
  endfunction

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40000 && !ok; c++) begin
      @(negedge CLK);
      #3;
      ok = drained();
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      words[i].delete();
      tails[i].delete();
      lens[i].delete();
    end
    expq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Driver: input FIFO heads, sink readiness and arbiter grant.
  initial begin
    int cand[$];
    int k;
    int len;
    select      = '0;
    grant_valid = 1'b0;
    in_valid    = '0;
    in_data     = '0;
    out_ready   = 1'b0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        in_valid[i] = (words[i].size() > 0) &&
                      ($urandom_range(0, 3) != 0);
        in_data[i*DW +: DW] =
          (words[i].size() > 0) ?
          words[i][0] : DW'($urandom);
      end
      out_ready  = ($urandom_range(0, 9) < 7);
      grant_prev = 1'b0;
      if (!nRST) begin
        grant_valid = 1'b0;
      end else if (!busy) begin
        cand.delete();
        for (int i = 0; i < N; i++)
          if (lens[i].size() > 0) cand.push_back(i);
        if (cand.size() > 0 &&
            $urandom_range(0, 4) != 0) begin
          k = cand[$urandom_range(0,
                   cand.size() - 1)];
          len = lens[k].pop_front();
          for (int j = 0; j <= len; j++)
            expq.push_back(words[k][j]);
          select      = SW'(k);
          grant_valid = 1'b1;
          granted     = k;
          grant_prev  = 1'b1;
        end else begin
          grant_valid = 1'b0;
          select      = SW'($urandom);
        end
      end else begin
        grant_valid = 1'(($urandom));
        select      = SW'($urandom);
      end
    end
  end

  // Protocol checker: pops, latency, stall, pkt_done, gap timing.
  initial begin
    logic [N-1:0]  pops;
    logic [N-1:0]  exp_done;
    logic [DW-1:0] prev_word;
    logic [DW-1:0] prev_out;
    bit            have_pop;
    bit            prev_stall;
    bit            pend_grant;
    int            since_tail;
    bit            t;
    have_pop   = 1'b0;
    prev_stall = 1'b0;
    pend_grant = 1'b0;
    since_tail = 0;
    prev_word  = '0;
    prev_out   = '0;
    forever begin
      @(negedge CLK);
      #4;
      if (!nRST) begin
        have_pop   = 1'b0;
        prev_stall = 1'b0;
        pend_grant = 1'b0;
        since_tail = 0;
      end else begin
        if (have_pop) begin
          chk("latency_valid", out_valid, 1);
          chk("latency_data", out_data, prev_word);
        end else if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_out);
        end
        if (pend_grant)
          chk("idle_to_hdr", busy, 1);
        pend_grant = grant_prev;
        if (since_tail > 0) begin
          if (since_tail < 3)
            chk("gap_busy", busy, 1);
          else
            chk("gap_end", busy, 0);
          since_tail = (since_tail == 3) ?
                       0 : since_tail + 1;
        end
        chk("in_ready_other",
            in_ready & ~(N'(1) << granted), 0);
        if (out_valid && !out_ready)
          chk("bp_in_ready", in_ready, 0);
        pops     = in_ready & in_valid;
        exp_done = '0;
        have_pop = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (pops[i]) begin
            prev_word = words[i].pop_front();
            t = tails[i].pop_front();
            exp_done[i] = t;
            have_pop = 1'b1;
            pop_cnt++;
            if (t) since_tail = 1;
          end
        end
        chk("pkt_done", pkt_done, exp_done);
        prev_stall = out_valid && !out_ready;
        prev_out   = out_data;
      end
    end
  end

  // Scoreboard monitor: every accepted output word in grant order.
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (nRST && out_valid && out_ready) begin
        if (expq.size() == 0)
          chk("sb_extra_word", 1, 0);
        else
          chk("sb_data", out_data, expq.pop_front());
      end
    end
  end

  // Sequencer: reset, random traffic, mid-packet reset, recovery.
  initial begin
    int base;
    bit ok;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    add_pkt(2, 3);
    add_pkt(0, 0);
    add_pkt(1, 255);
    add_pkt(3, 1);
    for (int p = 0; p < 30; p++)
      add_pkt($urandom_range(0, N - 1),
              $urandom_range(0, 12));
    wait_drain("drain_random");

    add_pkt(1, 20);
    base = pop_cnt;
    ok   = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge CLK);
      #4;
      ok = (pop_cnt - base >= 6);
    end
    chk("reach_payload", ok, 1'b1);
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_outs("midreset");
    clear_model();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    add_pkt(2, 1);
    wait_drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
